// File: rtl/text_pkg.sv
// Shared types and font-sheet geometry for the on-screen text blitter.
// Glyph codes 0..35 live in an 8-wide block at sheet pixel (32,64).
package text_pkg;

  localparam int GLYPH_W      = 8;
  localparam int GLYPH_H      = 8;
  localparam int SHEET_STRIDE = 160;
  localparam int FONT_X0      = 32;
  localparam int FONT_Y0      = 64;
  localparam int FONT_COLS    = 8;
  localparam int NUM_GLYPHS   = 36;

  typedef logic [5:0] glyph_code_t;

  localparam glyph_code_t SPACE_CODE = 6'd63;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    FETCH,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/font_addr.sv
// Maps a glyph code to the sprite-sheet address of its top-left pixel.
// Codes beyond the font fall back to glyph 0 ('A').
module font_addr
  import text_pkg::*;
(
  input  glyph_code_t  code,
  output logic [19:0]  base
);

  glyph_code_t idx;

  always_comb begin
    idx  = (code < 6'(NUM_GLYPHS)) ? code : 6'd0;
    base = 20'(FONT_Y0 * SHEET_STRIDE + FONT_X0)
         + 20'(idx[5:3]) * 20'(GLYPH_H * SHEET_STRIDE)
         + 20'({idx[2:0], 3'b000});
  end

endmodule

// File: rtl/text_blit_ctrl.sv
// Round-robin text request arbiter and glyph walker: copies 8x8 glyphs from
// the sprite ROM into the frame buffer, skipping transparent/off-screen pixels.
module text_blit_ctrl
  import text_pkg::*;
#(
  parameter int                MAX_CHARS = 8,
  parameter int                FB_W      = 640,
  parameter int                FB_H      = 480,
  parameter int                COLOR_W   = 8,
  parameter logic [COLOR_W-1:0] TRANSP   = '0,
  localparam int               LEN_W     = $clog2(MAX_CHARS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic [6*MAX_CHARS-1:0] req0_str,
  input  logic [LEN_W-1:0]       req0_len,
  input  logic [9:0]             req0_x,
  input  logic [8:0]             req0_y,
  output logic                   req0_ack,
  output logic                   req0_done,
  input  logic                   req1_valid,
  input  logic [6*MAX_CHARS-1:0] req1_str,
  input  logic [LEN_W-1:0]       req1_len,
  input  logic [9:0]             req1_x,
  input  logic [8:0]             req1_y,
  output logic                   req1_ack,
  output logic                   req1_done,
  output logic [19:0]            rom_addr,
  input  logic [COLOR_W-1:0]     rom_data,
  output logic                   fb_we,
  output logic [18:0]            fb_addr,
  output logic [COLOR_W-1:0]     fb_data,
  input  logic                   fb_ready,
  output logic                   busy
);

  localparam int CHAR_W = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;

  state_t                 state;
  logic                   grant;
  logic                   last_grant;
  logic                   wr_first;
  logic [6*MAX_CHARS-1:0] str_q;
  logic [LEN_W-1:0]       len_q;
  logic [9:0]             x_q;
  logic [8:0]             y_q;
  logic [CHAR_W-1:0]      char_idx;
  logic [2:0]             row;
  logic [2:0]             col;
  logic [COLOR_W-1:0]     pix_hold;

  glyph_code_t            cur_code;
  logic [19:0]            glyph_base;
  logic [19:0]            src_addr;
  logic [10:0]            px;
  logic [10:0]            py;
  logic [18:0]            lin_addr;
  logic [COLOR_W-1:0]     pix;
  logic                   on_screen;
  logic                   pix_we;
  logic                   stall;
  logic                   last_char;
  logic [LEN_W-1:0]       sel_len;

  assign cur_code = str_q[6*int'(char_idx) +: 6];

  font_addr u_font_addr (
    .code (cur_code),
    .base (glyph_base)
  );

  // Source and destination coordinates are derived from the walk counters.
  assign src_addr  = glyph_base + 20'(row) * 20'(SHEET_STRIDE) + 20'(col);
  assign px        = 11'(x_q) + 11'(char_idx) * 11'(GLYPH_W) + 11'(col);
  assign py        = 11'(y_q) + 11'(row);
  assign lin_addr  = 19'(py) * 19'(FB_W) + 19'(px);
  assign on_screen = (px < 11'(FB_W)) && (py < 11'(FB_H));

  // ROM data is only fresh on the first WRITE cycle; a stalled write replays
  // the captured copy so the frame-buffer port sees stable data.
  assign pix       = wr_first ? rom_data : pix_hold;
  assign pix_we    = (state == WRITE) && (pix != TRANSP) && on_screen;
  assign stall     = pix_we && !fb_ready;
  assign last_char = (int'(char_idx) + 1 == int'(len_q));
  assign sel_len   = grant ? req1_len : req0_len;

  assign req0_ack  = (state == GRANT) && !grant;
  assign req1_ack  = (state == GRANT) &&  grant;
  assign req0_done = (state == DONE)  && !grant;
  assign req1_done = (state == DONE)  &&  grant;
  assign busy      = (state != IDLE);
  assign rom_addr  = (state == FETCH || state == WRITE) ? src_addr : '0;
  assign fb_we     = pix_we;
  assign fb_addr   = (state == WRITE) ? lin_addr : '0;
  assign fb_data   = (state == WRITE) ? pix : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wr_first   <= 1'b0;
      len_q      <= '0;
      char_idx   <= '0;
      row        <= '0;
      col        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            grant <= (req0_valid && req1_valid) ? ~last_grant : req1_valid;
            state <= GRANT;
          end
        end

        GRANT: begin
          len_q      <= sel_len;
          char_idx   <= '0;
          row        <= '0;
          col        <= '0;
          last_grant <= grant;
          state      <= (sel_len == '0) ? DONE : FETCH;
        end

        // Spaces consume one FETCH cycle and never touch the ROM data path.
        FETCH: begin
          if (cur_code == SPACE_CODE) begin
            if (last_char) begin
              state <= DONE;
            end else begin
              char_idx <= char_idx + 1'b1;
            end
          end else begin
            wr_first <= 1'b1;
            state    <= WRITE;
          end
        end

        WRITE: begin
          wr_first <= 1'b0;
          if (!stall) begin
            if (col != 3'(GLYPH_W - 1)) begin
              col   <= col + 3'd1;
              state <= FETCH;
            end else begin
              col <= '0;
              if (row != 3'(GLYPH_H - 1)) begin
                row   <= row + 3'd1;
                state <= FETCH;
              end else begin
                row <= '0;
                if (last_char) begin
                  state <= DONE;
                end else begin
                  char_idx <= char_idx + 1'b1;
                  state    <= FETCH;
                end
              end
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  // Request payload and the captured pixel are pure data; they need no reset.
  always_ff @(posedge clk) begin
    if (state == GRANT) begin
      str_q <= grant ? req1_str : req0_str;
      x_q   <= grant ? req1_x   : req0_x;
      y_q   <= grant ? req1_y   : req0_y;
    end
    if (state == WRITE && wr_first) begin
      pix_hold <= rom_data;
    end
  end

endmodule

// File: tb/tb_text_blit_ctrl.sv
// Directed and randomized checks of text_blit_ctrl against a pixel-list model.
module tb_text_blit_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [47:0] req0_str = '0, req1_str = '0;
  logic [3:0]  req0_len = '0, req1_len = '0;
  logic [9:0]  req0_x = '0, req1_x = '0;
  logic [8:0]  req0_y = '0, req1_y = '0;
  logic        req0_ack, req1_ack, req0_done, req1_done;
  logic [19:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_ready;
  logic        busy;

  always #5 clk = ~clk;

  text_blit_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_str(req0_str), .req0_len(req0_len),
    .req0_x(req0_x), .req0_y(req0_y), .req0_ack(req0_ack), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_str(req1_str), .req1_len(req1_len),
    .req1_x(req1_x), .req1_y(req1_y), .req1_ack(req1_ack), .req1_done(req1_done),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
    .busy(busy)
  );

  int nchk = 0, nerr = 0;
  int cyc = 0;
  bit force_low = 0, rnd_stall = 0, rnd_bit = 0, rom_transp = 0;

  assign fb_ready = !(fb_we && (force_low || (rnd_stall && rnd_bit)));

  function automatic logic [7:0] rom_f(input logic [19:0] a);
    if (a[2:0] == 3'd5) return 8'h00;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rnd_bit  <= ($urandom_range(0, 3) == 0);
    rom_data <= rom_transp ? 8'h00 : rom_f(rom_addr);
  end

  int ack_cnt[2] = '{0, 0}, ack_cyc[2] = '{0, 0};
  int done_cnt[2] = '{0, 0}, done_cyc[2] = '{0, 0};
  int ack_last = -1000, stalls = 0;
  logic [19:0] rom_at1 = '0, rom_at129 = '0;
  int ack_order[$];
  logic [26:0] wr_q[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (req0_ack) begin ack_cnt[0] <= ack_cnt[0] + 1; ack_cyc[0] <= cyc; ack_last <= cyc; ack_order.push_back(0); end
      if (req1_ack) begin ack_cnt[1] <= ack_cnt[1] + 1; ack_cyc[1] <= cyc; ack_last <= cyc; ack_order.push_back(1); end
      if (req0_done) begin done_cnt[0] <= done_cnt[0] + 1; done_cyc[0] <= cyc; end
      if (req1_done) begin done_cnt[1] <= done_cnt[1] + 1; done_cyc[1] <= cyc; end
      if (fb_we && fb_ready) wr_q.push_back({fb_addr, fb_data});
      if (fb_we && !fb_ready) stalls <= stalls + 1;
      if (cyc == ack_last + 1) rom_at1 <= rom_addr;
      if (cyc == ack_last + 129) rom_at129 <= rom_addr;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: font block of 36 glyphs, 8 per sheet row, at sheet (32,64).
  function automatic int glyph_base(input int code);
    int c = (code < 36) ? code : 0;
    return (64 + (c / 8) * 8) * 160 + 32 + (c % 8) * 8;
  endfunction

  logic [26:0] exp_q[$];
  int cost_g, wr_base, stall_base, done_base, ack_base, cur_n;

  task automatic build_exp(input logic [47:0] s, input int len, input int x, input int y);
    exp_q.delete();
    cost_g = 0;
    for (int i = 0; i < len; i++) begin
      int code = int'(s[6*i +: 6]);
      if (code == 63) begin cost_g += 1; continue; end
      cost_g += 128;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          int a  = glyph_base(code) + r * 160 + c;
          logic [7:0] d = rom_transp ? 8'h00 : rom_f(20'(a));
          int px = x + 8 * i + c;
          int py = y + r;
          if (d != 8'h00 && px < 640 && py < 480) exp_q.push_back({19'(py * 640 + px), d});
        end
    end
  endtask

  function automatic logic [47:0] mkstr(input int c0, input int c1, input int c2);
    logic [47:0] s = '0;
    s[5:0] = 6'(c0); s[11:6] = 6'(c1); s[17:12] = 6'(c2);
    return s;
  endfunction

  task automatic start_req(input int n, input logic [47:0] s, input int len, input int x, input int y);
    int c0;
    bit got = 0;
    build_exp(s, len, x, y);
    wr_base = wr_q.size(); stall_base = stalls;
    done_base = done_cnt[n]; ack_base = ack_cnt[n]; cur_n = n;
    @(negedge clk);
    if (n == 0) begin
      req0_str = s; req0_len = 4'(len); req0_x = 10'(x); req0_y = 9'(y); req0_valid = 1;
    end else begin
      req1_str = s; req1_len = 4'(len); req1_x = 10'(x); req1_y = 9'(y); req1_valid = 1;
    end
    c0 = cyc;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack_cnt[n] != ack_base) begin got = 1; break; end
    end
    req0_valid = 0; req1_valid = 0;
    chk("ack_seen", got, 1);
    chk("ack_latency", ack_cyc[n] - c0, 1);
  endtask

  task automatic finish_req(output int lat);
    int bad = 0, nw;
    bit got = 0;
    for (int k = 0; k < 6000; k++) begin
      if (done_cnt[cur_n] != done_base) begin got = 1; break; end
      @(negedge clk);
    end
    chk("done_seen", got, 1);
    lat = done_cyc[cur_n] - ack_cyc[cur_n];
    chk("done_latency_model", lat, 1 + cost_g + (stalls - stall_base));
    nw = wr_q.size() - wr_base;
    chk("wr_count", nw, exp_q.size());
    for (int i = 0; i < nw && i < exp_q.size(); i++)
      if (wr_q[wr_base + i] !== exp_q[i]) bad++;
    chk("wr_pixels_bad", bad, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  initial begin
    int lat, ob, wb, d0, d1, dsave, bad;
    logic [18:0] a0;
    logic [7:0]  dd0;
    logic [47:0] s;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {busy, fb_we, req0_ack, req1_ack, req0_done, req1_done}, 0);
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_fb", {fb_addr, fb_data}, 0);
    rst = 0;
    @(negedge clk);

    // 1: "SC" at (100,50)
    start_req(0, mkstr(18, 2, 0), 2, 100, 50);
    chk("busy_active", busy, 1);
    finish_req(lat);
    chk("sc_first_rom", rom_at1, 12848);
    chk("sc_second_glyph_rom", rom_at129, 10288);
    chk("sc_done_latency", lat, 257);

    // 2: simultaneous requests alternate, starting with req0
    do_reset();
    ob = ack_order.size(); wb = wr_q.size();
    d0 = done_cnt[0]; d1 = done_cnt[1];
    @(negedge clk);
    req0_len = 0; req1_len = 0; req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 60 && ack_order.size() < ob + 4; k++) @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    repeat (6) @(negedge clk);
    chk("tie_ack_count", ack_order.size() >= ob + 4, 1);
    for (int k = 0; k < 4; k++)
      if (ob + k < ack_order.size()) chk("tie_order", ack_order[ob + k], k % 2);
    chk("tie_no_writes", wr_q.size() - wb, 0);
    chk("len0_done_latency", done_cyc[1] - ack_cyc[1], 1);
    chk("tie_done_count", {16'(done_cnt[0] - d0), 16'(done_cnt[1] - d1)}, {16'd2, 16'd2});
    chk("idle_after", busy, 0);

    // 3: fully transparent ROM
    rom_transp = 1;
    start_req(1, mkstr(18, 2, 0), 2, 100, 50);
    finish_req(lat);
    chk("transp_done_latency", lat, 257);
    rom_transp = 0;

    // 4: frame buffer refuses the first write for 5 cycles
    force_low = 1;
    start_req(0, mkstr(18, 2, 0), 2, 100, 50);
    for (int k = 0; k < 10 && !fb_we; k++) @(negedge clk);
    chk("stall_first_we", fb_we, 1);
    a0 = fb_addr; dd0 = fb_data;
    chk("stall_first_addr", a0, 50 * 640 + 100);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 4) force_low = 0;
      if (!(fb_we === 1'b1 && fb_addr === a0 && fb_data === dd0)) bad++;
    end
    chk("stall_hold_bad", bad, 0);
    @(negedge clk);
    chk("stall_advanced", fb_we, 0);
    finish_req(lat);
    chk("stall_done_latency", lat, 262);

    // 5: "A", space, "B"
    start_req(1, mkstr(0, 63, 1), 3, 200, 100);
    finish_req(lat);
    chk("space_done_latency", lat, 258);

    // 6: glyph clipped at the right edge
    start_req(0, mkstr(7, 0, 0), 1, 636, 10);
    finish_req(lat);
    bad = 0;
    for (int i = wr_base; i < wr_q.size(); i++)
      if (wr_q[i][26:8] % 640 < 636) bad++;
    chk("clip_cols_bad", bad, 0);
    chk("clip_has_writes", wr_q.size() > wr_base, 1);

    // 6b: reset in the middle of a glyph
    start_req(1, mkstr(18, 2, 0), 2, 100, 50);
    dsave = done_cnt[1];
    repeat (40) @(negedge clk);
    rst = 1;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_we", fb_we, 0);
    chk("midreset_rom", rom_addr, 0);
    @(negedge clk);
    rst = 0;
    repeat (300) @(negedge clk);
    chk("midreset_no_done", done_cnt[1], dsave);
    chk("midreset_idle", busy, 0);

    // Randomized requests with random back-pressure
    rnd_stall = 1;
    for (int it = 0; it < 8; it++) begin
      int n = $urandom_range(0, 1);
      int len = $urandom_range(0, 8);
      s = '0;
      for (int i = 0; i < 8; i++)
        s[6*i +: 6] = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 62));
      start_req(n, s, len, $urandom_range(0, 1023), (it % 2) ? $urandom_range(470, 511) : $urandom_range(0, 479));
      finish_req(lat);
    end
    rnd_stall = 0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
